three_split: RTL and testbench
==============================

Name: three_split

Overview:
- One-to-three stream distributor: a single valid/ready input stream is fanned out to three output channels, round-robin, skipping busy channels.
- It is the opposite direction of the team's three-input OR/combine cells: one source feeding three sinks, where those cells merge three sources into one.
- Used in the Education ModelSim projects as the sequential front end that feeds three independent consumers.

Parameters:
- Width, 8, data word width in bits (1..32).
- CntWidth, 8, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  Width  input word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  3*Width  channel i data in bits [i*Width +: Width].
- out_valid  output  3  channel i holds a word.
- out_ready  input  3  consumer i accepts its word this cycle.
- acc_cnt  output  CntWidth  number of words accepted since reset, modulo 2^CntWidth.

Behaviour:
- Clocking and reset
  - One clock; reset is synchronous and active-high.
  - On a clk edge with rst=1: out_valid=3'b000, out_data=0, acc_cnt=0, rr pointer ptr=0.
  - rst overrides any transfer in the same cycle; a word presented during reset is dropped and not counted.
- Storage
  - One holding register per channel: valid bit slot_v[i] plus data slot_d[i].
  - out_valid[i]=slot_v[i] and out_data slice i = slot_d[i], both driven directly from registers (no combinational path from inputs to outputs).
- Input handshake
  - in_ready = ~(slot_v[0] & slot_v[1] & slot_v[2]).
  - in_ready depends only on register state, never on in_valid or out_ready.
  - Accept occurs when in_valid & in_ready.
- Channel selection (round-robin, state ptr ∈ {0,1,2})
  - Scan order: ptr, ptr+1, ptr+2 (mod 3). The chosen channel c is the first with slot_v=0.
  - On accept: slot_d[c]<=in_data, slot_v[c]<=1, ptr<=(c+1) mod 3, acc_cnt<=acc_cnt+1 (wraps at 2^CntWidth-1 → 0).
  - With no accept, ptr and acc_cnt hold.
  - ptr value 3 is unreachable; if it is ever reached, the scan treats it as 0.
- Output handshake
  - out_valid[i] & out_ready[i] clears slot_v[i] at the next edge; slot_d[i] holds its last value.
  - A slot that drains in cycle t is not refilled in cycle t, because selection uses start-of-cycle slot_v. It becomes selectable at t+1.
- Latency and throughput
  - Accepted word appears on its channel's out_valid one cycle after the accept edge.
  - Sustained rate is one word per cycle when all consumers are always ready: each slot alternates fill/drain and round-robin rotates across the three slots.
- Boundary conditions
  - All slots full: in_ready=0, the input word is held by the source, nothing changes except drains.
  - Simultaneous accept and drains in the same cycle: both take effect, on different slots.
  - out_ready on an empty channel: ignored.
  - in_valid=0: no state change other than drains.

Decomposition:
- No shared package needed.
- Local constants: NCH=3 and the ptr width of 2.
- One natural sub-module: three_split_pick, a combinational rr first-free selector.
  - Inputs: slot_v[2:0], ptr[1:0].
  - Outputs: c[1:0], any_free.
  - Reusable for a later three-input arbiter.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1 -> out_valid=000, acc_cnt=0, in_ready=1 after release, no word stored.
- Rotation: out_ready=111, send 0x11,0x22,0x33,0x44 on consecutive cycles -> appear on ch0,ch1,ch2,ch0 each one cycle later; in_ready stays 1; acc_cnt=4.
- Skip busy: out_ready=000, send 0xA1 (→ch0); then send 0xA2 with ch1 pre-filled -> 0xA2 goes to ch2, ptr=0.
- Full stall: out_ready=000, send 4 words -> first three fill ch0..ch2, in_ready=0, 4th held; raise out_ready[1] one cycle -> ch1 drains, next cycle 4th word lands in ch1.
- Counter wrap: CntWidth=4, stream 17 words with out_ready=111 -> acc_cnt=1.
- Mid-operation reset: slots full with ptr=2, assert rst with in_valid=1 and out_ready=111 -> next cycle all cleared, ptr=0, acc_cnt=0, nothing counted.

Source files
------------

// File: rtl/three_split_pkg.sv
`default_nettype none
// ============================================================================
// Module      : three_split_pkg
// Description : Shared constants and round-robin pointer helpers for the
//               one-to-three stream distributor.
// Revision    : 1.0 - initial release
// ============================================================================
package three_split_pkg;

   localparam int NCH   = 3;
   localparam int PTR_W = 2;

   // Pointer value 3 cannot be reached; if it ever appears, scan from channel 0.
   function automatic logic [PTR_W-1:0] rr_norm(input logic [PTR_W-1:0] x);
      return (x == 2'd3) ? 2'd0 : x;
   endfunction

   function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] x);
      return (x >= 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

endpackage : three_split_pkg
`default_nettype wire

// File: rtl/three_split_pick.sv
`default_nettype none
// ============================================================================
// Module      : three_split_pick
// Description : Combinational round-robin first-free selector over three slots.
// Revision    : 1.0 - initial release
// ============================================================================
module three_split_pick
   import three_split_pkg::*;
(
   input  logic [NCH-1:0]   i_slot_v,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [PTR_W-1:0] o_c,
   output logic             o_any_free
);

   logic [PTR_W-1:0] w_p0;
   logic [PTR_W-1:0] w_p1;
   logic [PTR_W-1:0] w_p2;

   assign w_p0 = rr_norm(i_ptr);
   assign w_p1 = rr_next(w_p0);
   assign w_p2 = rr_next(w_p1);

   assign o_any_free = ~(&i_slot_v);

   // o_c is only meaningful when o_any_free is set.
   always_comb begin
      o_c = w_p0;
      if (!i_slot_v[w_p0]) begin
         o_c = w_p0;
      end else if (!i_slot_v[w_p1]) begin
         o_c = w_p1;
      end else if (!i_slot_v[w_p2]) begin
         o_c = w_p2;
      end
   end

endmodule : three_split_pick
`default_nettype wire

// File: rtl/three_split.sv
`default_nettype none
// ============================================================================
// Module      : three_split
// Description : One-to-three valid/ready distributor, round-robin over free
//               channels, with one registered holding slot per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module three_split
   import three_split_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [NCH*WIDTH-1:0]   out_data,
   output logic [NCH-1:0]         out_valid,
   input  logic [NCH-1:0]         out_ready,
   output logic [CNT_WIDTH-1:0]   acc_cnt
);

   logic [NCH-1:0]       r_slot_v;
   logic [WIDTH-1:0]     r_slot_d [NCH];
   logic [PTR_W-1:0]     r_ptr;
   logic [CNT_WIDTH-1:0] r_acc_cnt;

   logic [PTR_W-1:0]     w_c;
   logic                 w_any_free;
   logic                 w_accept;

   three_split_pick u_pick (
      .i_slot_v   (r_slot_v),
      .i_ptr      (r_ptr),
      .o_c        (w_c),
      .o_any_free (w_any_free)
   );

   assign in_ready = w_any_free;
   assign w_accept = in_valid & w_any_free;

   // Selection sees start-of-cycle occupancy, so a slot draining now is never
   // the one being filled; drain and fill always target different slots.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot_v  <= '0;
         r_ptr     <= '0;
         r_acc_cnt <= '0;
         for (int i = 0; i < NCH; i++) begin
            r_slot_d[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (r_slot_v[i] && out_ready[i]) begin
               r_slot_v[i] <= 1'b0;
            end
         end
         if (w_accept) begin
            r_slot_v[w_c] <= 1'b1;
            r_slot_d[w_c] <= in_data;
            r_ptr         <= rr_next(w_c);
            r_acc_cnt     <= r_acc_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign out_valid = r_slot_v;
   assign acc_cnt   = r_acc_cnt;

   for (genvar g = 0; g < NCH; g++) begin : g_out
      assign out_data[g*WIDTH +: WIDTH] = r_slot_d[g];
   end

endmodule : three_split
`default_nettype wire

// File: tb/tb_three_split.sv
`default_nettype none
// ============================================================================
// Module      : tb_three_split
// Description : Directed table-driven bench for three_split (8-bit counter
//               instance plus a 4-bit counter instance sharing the stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_three_split;

   logic        clk;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic [2:0]  out_ready;

   logic        in_ready;
   logic [23:0] out_data;
   logic [2:0]  out_valid;
   logic [7:0]  acc_cnt;

   logic        in_ready4;
   logic [23:0] out_data4;
   logic [2:0]  out_valid4;
   logic [3:0]  acc_cnt4;

   int n_cmp = 0;
   int n_err = 0;

   three_split #(.WIDTH(8), .CNT_WIDTH(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc_cnt   (acc_cnt)
   );

   three_split #(.WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready4),
      .out_data  (out_data4),
      .out_valid (out_valid4),
      .out_ready (out_ready),
      .acc_cnt   (acc_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        iv;
      logic [7:0]  d;
      logic [2:0]  ordy;
      logic [2:0]  e_ov;
      logic        e_ir;
      logic [7:0]  e_cnt;
      logic [23:0] e_data;
   } vec_t;

   localparam int NVEC = 21;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [7:0] d,
                       input logic [2:0] ordy);
      rst       = r;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 3'b000;

      //              rst   iv    data   ordy    ov      ir    cnt    {ch2,ch1,ch0}
      vecs[0]  = '{1'b1, 1'b1, 8'h55, 3'b000, 3'b000, 1'b1, 8'd0, 24'h000000};
      vecs[1]  = '{1'b1, 1'b1, 8'h66, 3'b111, 3'b000, 1'b1, 8'd0, 24'h000000};
      vecs[2]  = '{1'b0, 1'b1, 8'h11, 3'b111, 3'b001, 1'b1, 8'd1, 24'h000011};
      vecs[3]  = '{1'b0, 1'b1, 8'h22, 3'b111, 3'b010, 1'b1, 8'd2, 24'h002211};
      vecs[4]  = '{1'b0, 1'b1, 8'h33, 3'b111, 3'b100, 1'b1, 8'd3, 24'h332211};
      vecs[5]  = '{1'b0, 1'b1, 8'h44, 3'b111, 3'b001, 1'b1, 8'd4, 24'h332244};
      vecs[6]  = '{1'b0, 1'b0, 8'h99, 3'b111, 3'b000, 1'b1, 8'd4, 24'h332244};
      vecs[7]  = '{1'b1, 1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 8'd0, 24'h000000};
      vecs[8]  = '{1'b0, 1'b1, 8'hC0, 3'b000, 3'b001, 1'b1, 8'd1, 24'h0000C0};
      vecs[9]  = '{1'b0, 1'b1, 8'hC1, 3'b000, 3'b011, 1'b1, 8'd2, 24'h00C1C0};
      vecs[10] = '{1'b0, 1'b1, 8'hC2, 3'b000, 3'b111, 1'b0, 8'd3, 24'hC2C1C0};
      vecs[11] = '{1'b0, 1'b1, 8'hC3, 3'b000, 3'b111, 1'b0, 8'd3, 24'hC2C1C0};
      vecs[12] = '{1'b0, 1'b1, 8'hC3, 3'b010, 3'b101, 1'b1, 8'd3, 24'hC2C1C0};
      vecs[13] = '{1'b0, 1'b1, 8'hC3, 3'b000, 3'b111, 1'b0, 8'd4, 24'hC2C3C0};
      vecs[14] = '{1'b0, 1'b0, 8'h00, 3'b101, 3'b010, 1'b1, 8'd4, 24'hC2C3C0};
      vecs[15] = '{1'b0, 1'b1, 8'hA0, 3'b000, 3'b110, 1'b1, 8'd5, 24'hA0C3C0};
      vecs[16] = '{1'b0, 1'b1, 8'hA1, 3'b100, 3'b011, 1'b1, 8'd6, 24'hA0C3A1};
      vecs[17] = '{1'b0, 1'b1, 8'hA2, 3'b000, 3'b111, 1'b0, 8'd7, 24'hA2C3A1};
      vecs[18] = '{1'b0, 1'b0, 8'h00, 3'b111, 3'b000, 1'b1, 8'd7, 24'hA2C3A1};
      vecs[19] = '{1'b0, 1'b1, 8'h5A, 3'b000, 3'b001, 1'b1, 8'd8, 24'hA2C35A};
      vecs[20] = '{1'b0, 1'b0, 8'h00, 3'b110, 3'b001, 1'b1, 8'd8, 24'hA2C35A};

      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].ordy);
         chk("out_valid", i, 32'(out_valid), 32'(vecs[i].e_ov));
         chk("in_ready",  i, 32'(in_ready),  32'(vecs[i].e_ir));
         chk("acc_cnt",   i, 32'(acc_cnt),   32'(vecs[i].e_cnt));
         chk("acc_cnt4",  i, 32'(acc_cnt4),  32'(vecs[i].e_cnt[3:0]));
         chk("out_data",  i, 32'(out_data),  32'(vecs[i].e_data));
      end

      // Counter wrap: 17 words through a 4-bit counter leaves 1.
      step(1'b1, 1'b0, 8'h00, 3'b111);
      chk("wrap_rst_cnt4", 100, 32'(acc_cnt4), 32'd0);
      for (int k = 0; k < 17; k++) begin
         step(1'b0, 1'b1, 8'(k + 1), 3'b111);
         chk("wrap_in_ready", 101 + k, 32'(in_ready), 32'd1);
      end
      chk("wrap_cnt8", 120, 32'(acc_cnt),  32'd17);
      chk("wrap_cnt4", 121, 32'(acc_cnt4), 32'd1);

      // Mid-operation reset with all slots full and ptr=2.
      step(1'b1, 1'b0, 8'h00, 3'b000);
      step(1'b0, 1'b1, 8'hD0, 3'b000);
      step(1'b0, 1'b1, 8'hD1, 3'b000);
      step(1'b0, 1'b1, 8'hD2, 3'b000);
      step(1'b0, 1'b0, 8'h00, 3'b010);
      step(1'b0, 1'b1, 8'hD3, 3'b000);
      chk("mid_full_ov",   130, 32'(out_valid), 32'b111);
      chk("mid_full_data", 131, 32'(out_data),  32'hD2D3D0);
      chk("mid_full_cnt",  132, 32'(acc_cnt),   32'd4);
      step(1'b1, 1'b1, 8'hEE, 3'b111);
      chk("mid_rst_ov",    133, 32'(out_valid), 32'b000);
      chk("mid_rst_data",  134, 32'(out_data),  32'h000000);
      chk("mid_rst_cnt",   135, 32'(acc_cnt),   32'd0);
      chk("mid_rst_ir",    136, 32'(in_ready),  32'd1);
      step(1'b0, 1'b1, 8'hF0, 3'b000);
      chk("post_rst_ov",   137, 32'(out_valid), 32'b001);
      chk("post_rst_data", 138, 32'(out_data),  32'h0000F0);
      chk("post_rst_cnt",  139, 32'(acc_cnt),   32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_three_split
`default_nettype wire
